// File: rtl/rr_arb_1hot.sv
// -----------------------------------------------------------------------------
// rr_arb_1hot
//
// Round-robin arbiter with a registered one-hot grant. It sits directly in
// front of a one-hot datapath mux: gnt is the mux select, so it is only ever
// zero or exactly one-hot. Multi-beat transfers are supported: with LOCK=1 the
// grant is held until the consumer acks the granted requester's last beat.
//
// Parameters
//   N     number of requesters (2..32)
//   LOCK  1: hold grant until ack with req_last[g]; 0: release on every ack
//   IW    width of gnt_idx, $clog2(N)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req        per-requester request level
//   req_last   per-requester last-beat flag, only the granted bit is used
//   ack        consumer accepted one beat from the granted source
//   gnt        registered one-hot grant (or zero), mux select
//   gnt_valid  |gnt
//   gnt_idx    binary index of the granted requester, 0 when idle
//   busy       high while a grant is held
// -----------------------------------------------------------------------------
module rr_arb_1hot #(
    parameter int N    = 8,
    parameter bit LOCK = 1'b1,
    parameter int IW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  req_last,
    input  logic          ack,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic          busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]    state_q,   state_d;
    logic [IW-1:0] ptr_q,     ptr_d;
    logic [N-1:0]  gnt_q,     gnt_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;

    // Grant-termination terms, all evaluated against the current grant index.
    logic          release_w;
    logic          abort_w;
    logic          end_w;
    logic [IW-1:0] next_ptr;

    // Search start: in GRANT the search for the successor already uses the
    // post-release pointer so a new grant loads without an idle bubble.
    logic [IW-1:0] base;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        release_w = ack && (!LOCK || req_last[gnt_idx_q]);
        abort_w   = !req[gnt_idx_q];
        end_w     = (state_q == ST_GRANT) && (release_w || abort_w);
        next_ptr  = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
        base      = (state_q == ST_GRANT) ? next_ptr : ptr_q;
    end

    // First set request in the circular order base, base+1, ..., base-1.
    // The released requester sits last in that order, so it is re-granted
    // only when nobody else is asking.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, otherwise paths that skip the assignment infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, base} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            idx = sum[IW-1:0];
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    gnt_idx_d      = win_idx;
                    state_d        = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Release and abort share one path: ack in the same cycle as
                // an abort is simply one release. Without either, the grant
                // is held and other requests cannot preempt it.
                if (end_w) begin
                    ptr_d = next_ptr;
                    if (win_found) begin
                        gnt_d          = '0;
                        gnt_d[win_idx] = 1'b1;
                        gnt_idx_d      = win_idx;
                    end else begin
                        gnt_d     = '0;
                        gnt_idx_d = '0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                gnt_d     = '0;
                gnt_idx_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // NOTE: reset is synchronous here; rst is only looked at on the clock edge,
    // so an in-flight grant drops on the next edge with no release handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignment so every flop
            // samples the pre-edge values regardless of statement order.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_arb_1hot.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_1hot
//
// Two arbiters (LOCK=1 and LOCK=0) share one stimulus stream. A behavioural
// model per instance (granted index, valid flag, priority pointer) predicts
// gnt / gnt_valid / gnt_idx / busy every cycle. Directed scenarios add
// constant expectations; a random phase adds a starvation bound.
// -----------------------------------------------------------------------------
module tb_rr_arb_1hot;

    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  req_last;
    logic          ack;

    logic [N-1:0]  gnt_o   [2];
    logic          valid_o [2];
    logic [IW-1:0] idx_o   [2];
    logic          busy_o  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = LOCK=1 instance, 1 = LOCK=0 instance.
    bit m_valid [2];
    int m_idx   [2];
    int m_ptr   [2];

    logic [N-1:0] prev_gnt [2];
    int           wait_cnt [2][N];

    logic [7:0] s2_gnt [7] = '{8'h01, 8'h01, 8'h01, 8'h04, 8'h04, 8'h04, 8'h01};
    int         s2_idx [7] = '{0, 0, 0, 2, 2, 2, 0};

    always #5 clk = ~clk;

    rr_arb_1hot #(.N(N), .LOCK(1'b1)) dut_l1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_last  (req_last),
        .ack       (ack),
        .gnt       (gnt_o[0]),
        .gnt_valid (valid_o[0]),
        .gnt_idx   (idx_o[0]),
        .busy      (busy_o[0])
    );

    rr_arb_1hot #(.N(N), .LOCK(1'b0)) dut_l0 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_last  (req_last),
        .ack       (ack),
        .gnt       (gnt_o[1]),
        .gnt_valid (valid_o[1]),
        .gnt_idx   (idx_o[1]),
        .busy      (busy_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // First requester found walking p, p+1, ... around the ring; -1 if none.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_update(input int k, input bit lock);
        int w;
        int g;
        if (rst) begin
            m_valid[k] = 1'b0;
            m_idx[k]   = 0;
            m_ptr[k]   = 0;
        end else if (!m_valid[k]) begin
            w = rr_pick(req, m_ptr[k]);
            if (w >= 0) begin
                m_valid[k] = 1'b1;
                m_idx[k]   = w;
            end
        end else begin
            g = m_idx[k];
            if ((ack && (!lock || req_last[g])) || !req[g]) begin
                m_ptr[k] = (g + 1) % N;
                w = rr_pick(req, m_ptr[k]);
                if (w >= 0) begin
                    m_idx[k] = w;
                end else begin
                    m_valid[k] = 1'b0;
                    m_idx[k]   = 0;
                end
            end
        end
    endtask

    task automatic track_starvation(input int k);
        if (rst) begin
            for (int i = 0; i < N; i++) wait_cnt[k][i] = 0;
        end else if (gnt_o[k] != '0 && gnt_o[k] != prev_gnt[k]) begin
            for (int i = 0; i < N; i++) begin
                if (gnt_o[k][i]) begin
                    wait_cnt[k][i] = 0;
                end else if (req[i]) begin
                    wait_cnt[k][i]++;
                    check(k == 0 ? "l1_no_starve" : "l0_no_starve",
                          32'(wait_cnt[k][i] <= N - 1), 32'd1);
                end else begin
                    wait_cnt[k][i] = 0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) wait_cnt[k][i] = 0;
            end
        end
        prev_gnt[k] = gnt_o[k];
    endtask

    // One clock: update models with the inputs seen at the edge, then compare
    // both instances 1 ns after it.
    task automatic step();
        logic [N-1:0] exp_gnt;
        @(posedge clk);
        model_update(0, 1'b1);
        model_update(1, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_gnt = m_valid[k] ? (N'(1) << m_idx[k]) : '0;
            check(k == 0 ? "l1_gnt"   : "l0_gnt",   32'(gnt_o[k]),   32'(exp_gnt));
            check(k == 0 ? "l1_valid" : "l0_valid", 32'(valid_o[k]), 32'(m_valid[k]));
            check(k == 0 ? "l1_idx"   : "l0_idx",   32'(idx_o[k]),   32'(m_idx[k]));
            check(k == 0 ? "l1_busy"  : "l0_busy",  32'(busy_o[k]),  32'(m_valid[k]));
            check(k == 0 ? "l1_onehot0" : "l0_onehot0", 32'($onehot0(gnt_o[k])), 32'd1);
            track_starvation(k);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        req_last = '0;
        ack      = 1'b0;
        step();
        rst      = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        req         = '0;
        req_last    = '0;
        ack         = 1'b0;
        prev_gnt[0] = '0;
        prev_gnt[1] = '0;

        // Reset state and idle behaviour.
        do_reset();
        check("rst_gnt",   32'(gnt_o[0]),   32'h0);
        check("rst_valid", 32'(valid_o[0]), 32'h0);
        check("rst_idx",   32'(idx_o[0]),   32'h0);
        check("rst_busy",  32'(busy_o[0]),  32'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            check("idle_gnt",  32'(gnt_o[0]),  32'h0);
            check("idle_busy", 32'(busy_o[0]), 32'h0);
        end
        req = 8'h04;
        step();
        check("one_req_gnt", 32'(gnt_o[0]), 32'h04);
        rst = 1'b1;
        step();
        check("mid_rst_gnt",  32'(gnt_o[0]),  32'h0);
        check("mid_rst_busy", 32'(busy_o[0]), 32'h0);
        rst = 1'b0;

        // LOCK=1, requesters 0 and 2, three beats each, ack every cycle.
        do_reset();
        req = 8'h05;
        ack = 1'b1;
        for (int t = 0; t < 7; t++) begin
            req_last = (t == 3 || t == 6) ? '1 : '0;
            step();
            check("burst_gnt", 32'(gnt_o[0]), 32'(s2_gnt[t]));
            check("burst_idx", 32'(idx_o[0]), 32'(s2_idx[t]));
        end

        // LOCK=0, everyone requesting, ack every cycle: walk with wrap.
        do_reset();
        req      = 8'hFF;
        ack      = 1'b1;
        req_last = '0;
        for (int k = 0; k < 17; k++) begin
            step();
            check("walk_gnt", 32'(gnt_o[1]), 32'(N'(1) << (k % N)));
        end

        // LOCK=1: hold 8'h02 with no ack, then release on req_last[1].
        do_reset();
        req = 8'hFF;
        step();
        check("hold_first", 32'(gnt_o[0]), 32'h01);
        ack      = 1'b1;
        req_last = 8'h01;
        step();
        check("hold_second", 32'(gnt_o[0]), 32'h02);
        ack      = 1'b0;
        req_last = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("hold_gnt", 32'(gnt_o[0]), 32'h02);
        end
        ack      = 1'b1;
        req_last = 8'h02;
        step();
        check("hold_release", 32'(gnt_o[0]), 32'h04);

        // Abort with another requester waiting; ptr must land on 4.
        do_reset();
        req = 8'h08;
        step();
        check("abort_start", 32'(gnt_o[0]), 32'h08);
        req = 8'h10;
        step();
        check("abort_switch", 32'(gnt_o[0]), 32'h10);
        req      = 8'hFF;
        ack      = 1'b1;
        req_last = 8'hFF;
        step();
        check("abort_ptr", 32'(gnt_o[0]), 32'h20);

        // Abort with nobody else waiting.
        do_reset();
        req = 8'h08;
        step();
        req = 8'h00;
        step();
        check("abort_idle_gnt",  32'(gnt_o[0]),  32'h0);
        check("abort_idle_busy", 32'(busy_o[0]), 32'h0);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            rst      = ($urandom_range(0, 1999) == 0);
            req      = req ^ (N'($urandom) & N'($urandom) & N'($urandom));
            ack      = 1'($urandom_range(0, 1));
            req_last = N'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
